// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the RV32I control pipeline: opcodes, ALU ops, result and
// immediate selects, and the control word carried from Decode into Execute.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // funct3 rides along so Execute can pick the branch condition.
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_op_e     alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        pc_target_src;
    logic [2:0]  funct3;
  } ctrl_word_t;

  // Only the fields that still matter after Execute.
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
  } m_ctrl_t;

  // Shared R-type / I-type ALU select; alt is funct7_5 where it is meaningful.
  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_pipe_if.sv
// Control-unit bus: Decode instruction fields, hazard flush, ALU flags in;
// Decode/Execute/Memory/Writeback control out.
interface riscv_ctrl_pipe_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       funct7_0;
  logic       FlushE;
  logic       ZeroE;
  logic       LtE;
  logic       LtuE;
  logic [2:0] ImmSrcD;
  logic       IllegalD;
  logic [3:0] AluControlE;
  logic       AluSrcAE;
  logic       AluSrcBE;
  logic       PCSrcE;
  logic       PCTargetSrcE;
  logic [1:0] ResultSrcE;
  logic [1:0] ResultSrcM;
  logic [1:0] ResultSrcW;
  logic       RegWriteE;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       MemWriteM;

  modport master (
    output op, funct3, funct7_5, funct7_0, FlushE, ZeroE, LtE, LtuE,
    input  ImmSrcD, IllegalD, AluControlE, AluSrcAE, AluSrcBE, PCSrcE,
           PCTargetSrcE, ResultSrcE, ResultSrcM, ResultSrcW,
           RegWriteE, RegWriteM, RegWriteW, MemWriteM
  );

  modport slave (
    input  op, funct3, funct7_5, funct7_0, FlushE, ZeroE, LtE, LtuE,
    output ImmSrcD, IllegalD, AluControlE, AluSrcAE, AluSrcBE, PCSrcE,
           PCTargetSrcE, ResultSrcE, ResultSrcM, ResultSrcW,
           RegWriteE, RegWriteM, RegWriteW, MemWriteM
  );
endinterface

// File: rtl/riscv_ctrl_decode.sv
// Pure combinational Decode: instruction fields to control word, immediate
// select and illegal flag. Illegal encodings produce an all-zero bubble.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit SUPPORT_MUL   = 1'b0,
  parameter bit SUPPORT_UPPER = 1'b1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  output ctrl_word_t cw,
  output imm_src_e   imm_src,
  output logic       illegal
);

  // Opcode decode; the illegal squash at the end overrides any partial word.
  always_comb begin
    cw      = '0;
    imm_src = IMM_I;
    illegal = 1'b0;
    case (op)
      OP_LOAD: begin
        cw.reg_write  = 1'b1;
        cw.alu_src_b  = 1'b1;
        cw.result_src = RES_MEM;
      end
      OP_STORE: begin
        cw.mem_write = 1'b1;
        cw.alu_src_b = 1'b1;
        imm_src      = IMM_S;
      end
      OP_R: begin
        if (funct7_0) begin
          if (SUPPORT_MUL && funct3 == 3'b000) begin
            cw.reg_write = 1'b1;
            cw.alu_op    = ALU_MUL;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          cw.reg_write = 1'b1;
          cw.alu_op    = alu_dec(funct3, funct7_5);
        end
      end
      OP_I: begin
        // bit 30 is immediate data except on shifts-right (srli/srai)
        cw.reg_write = 1'b1;
        cw.alu_src_b = 1'b1;
        cw.alu_op    = alu_dec(funct3, (funct3 == 3'b101) && funct7_5);
      end
      OP_BR: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          illegal = 1'b1;
        end else begin
          cw.branch = 1'b1;
          cw.alu_op = ALU_SUB;
          cw.funct3 = funct3;
          imm_src   = IMM_B;
        end
      end
      OP_JAL: begin
        cw.jump       = 1'b1;
        cw.reg_write  = 1'b1;
        cw.result_src = RES_PC4;
        imm_src       = IMM_J;
      end
      OP_JALR: begin
        cw.jump          = 1'b1;
        cw.reg_write     = 1'b1;
        cw.alu_src_b     = 1'b1;
        cw.result_src    = RES_PC4;
        cw.pc_target_src = 1'b1;
      end
      OP_LUI: begin
        if (SUPPORT_UPPER) begin
          cw.reg_write  = 1'b1;
          cw.result_src = RES_IMM;
          imm_src       = IMM_U;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (SUPPORT_UPPER) begin
          cw.reg_write = 1'b1;
          cw.alu_src_a = 1'b1;
          cw.alu_src_b = 1'b1;
          imm_src      = IMM_U;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      cw      = '0;
      imm_src = IMM_I;
    end
  end

endmodule

// File: rtl/riscv_ctrl_pipe.sv
// Pipelined control unit: Decode sub-module, then E/M/W control registers and
// branch/jump resolution in Execute. Stalls are handled outside by the hazard
// unit holding F/D and flushing E, so there is no enable here.
module riscv_ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter bit SUPPORT_MUL   = 1'b0,
  parameter bit SUPPORT_UPPER = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  riscv_ctrl_pipe_if.slave   bus
);

  ctrl_word_t  ctrl_d, ctrl_e;
  imm_src_e    imm_src_d;
  logic        illegal_d;
  m_ctrl_t     ctrl_m;
  logic        reg_write_w;
  result_src_e result_src_w;
  logic        taken_e;

  riscv_ctrl_decode #(
    .SUPPORT_MUL   (SUPPORT_MUL),
    .SUPPORT_UPPER (SUPPORT_UPPER)
  ) u_dec (
    .op       (bus.op),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .funct7_0 (bus.funct7_0),
    .cw       (ctrl_d),
    .imm_src  (imm_src_d),
    .illegal  (illegal_d)
  );

  // Execute register: a flush inserts a bubble so nothing downstream writes.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) ctrl_e <= '0;
    else                     ctrl_e <= ctrl_d;
  end

  // Memory and Writeback registers advance unconditionally.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_m       <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= RES_ALU;
    end else begin
      ctrl_m       <= '{reg_write:  ctrl_e.reg_write,
                        result_src: ctrl_e.result_src,
                        mem_write:  ctrl_e.mem_write};
      reg_write_w  <= ctrl_m.reg_write;
      result_src_w <= ctrl_m.result_src;
    end
  end

  // Branch condition from the ALU flags of the compare running in Execute.
  always_comb begin
    taken_e = 1'b0;
    case (ctrl_e.funct3)
      3'b000:  taken_e =  bus.ZeroE;
      3'b001:  taken_e = !bus.ZeroE;
      3'b100:  taken_e =  bus.LtE;
      3'b101:  taken_e = !bus.LtE;
      3'b110:  taken_e =  bus.LtuE;
      3'b111:  taken_e = !bus.LtuE;
      default: taken_e = 1'b0;
    endcase
  end

  assign bus.ImmSrcD      = imm_src_d;
  assign bus.IllegalD     = illegal_d;
  assign bus.AluControlE  = ctrl_e.alu_op;
  assign bus.AluSrcAE     = ctrl_e.alu_src_a;
  assign bus.AluSrcBE     = ctrl_e.alu_src_b;
  assign bus.PCSrcE       = ctrl_e.jump | (ctrl_e.branch & taken_e);
  assign bus.PCTargetSrcE = ctrl_e.pc_target_src;
  assign bus.ResultSrcE   = ctrl_e.result_src;
  assign bus.RegWriteE    = ctrl_e.reg_write;
  assign bus.ResultSrcM   = ctrl_m.result_src;
  assign bus.RegWriteM    = ctrl_m.reg_write;
  assign bus.MemWriteM    = ctrl_m.mem_write;
  assign bus.ResultSrcW   = result_src_w;
  assign bus.RegWriteW    = reg_write_w;

endmodule
